pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, default 64, SHALL set the payload width (e.g. PC and instruction concatenated).
REQ-002 Parameter ZERO_BUBBLE, default 1, SHALL force outData to all-zero (NOP bubble) whenever outValid is 0; when 0, outData SHALL hold its last value.
REQ-003 Port clk, input, 1 bit, SHALL be the clock; rising edge active.
REQ-004 Port rstN, input, 1 bit, SHALL be the reset: asynchronous, active-low.
REQ-005 Port inValid, input, 1 bit, SHALL indicate the upstream stage offers inData.
REQ-006 Port inData, input, DATA_W bits, SHALL be the upstream payload.
REQ-007 Port inReady, output, 1 bit, SHALL indicate the block accepts a beat this cycle.
REQ-008 Port outValid, output, 1 bit, SHALL indicate outData is a valid beat.
REQ-009 Port outData, output, DATA_W bits, SHALL be the downstream payload.
REQ-010 Port outReady, input, 1 bit, SHALL indicate downstream consumes the beat (hazard stall when 0).
REQ-011 Port flush, input, 1 bit, SHALL discard all held beats (branch/jump squash).
REQ-012 Port occupancy, output, 2 bits, SHALL report held beats (0, 1 or 2).

Function
REQ-013 Transfer in SHALL occur on a rising edge when inValid and inReady are both 1; transfer out when outValid and outReady are both 1.
REQ-014 The block SHALL hold a main register and a one-entry skid register, giving states EMPTY (0 beats), HALF (main only), FULL (main and skid).
REQ-015 inReady SHALL be a registered signal equal to 1 exactly when the skid is empty (states EMPTY, HALF), with no combinational path from outReady.
REQ-016 outValid SHALL be 1 in HALF and FULL, 0 in EMPTY; outData SHALL come from the main register.
REQ-017 EMPTY: transfer in SHALL move to HALF with the beat in main; latency in to out SHALL be one cycle.
REQ-018 HALF: in plus out together SHALL load main with the new beat and stay HALF; out only SHALL go to EMPTY; in only SHALL store the beat in skid and go to FULL.
REQ-019 FULL: transfer out SHALL move skid to main and go to HALF; no transfer in SHALL occur because inReady is 0.
REQ-020 Beat order SHALL be preserved: no beat dropped, duplicated or reordered except by flush.
REQ-021 flush SHALL take priority over every transfer: on the edge with flush 1, the next state SHALL be EMPTY, a coincident input beat SHALL be discarded, and inReady SHALL be 1 the following cycle.
REQ-022 A downstream transfer during a flush cycle SHALL still count as consumed by downstream; the block SHALL NOT replay it.
REQ-023 occupancy SHALL equal 0, 1, 2 for EMPTY, HALF, FULL, registered.
REQ-024 Payload registers SHALL load only on an accepted transfer; a stall (outReady 0) SHALL hold outData stable.

Reset
REQ-025 On rstN low, the state SHALL become EMPTY immediately, independent of clk.
REQ-026 Reset values: outValid 0, outData 0, inReady 1, occupancy 0, skid contents 0.
REQ-027 Reset asserted mid-transfer SHALL discard all held beats; the first edge after rstN rises SHALL behave as EMPTY.

Structure
REQ-028 The state enumeration (EMPTY, HALF, FULL) and the 32-bit NOP encoding SHALL live in the shared pipeline package.
REQ-029 The block SHALL be a single module with no sub-modules; the IF/ID, ID/EX, EX/MEM and MEM/WB stages SHALL instantiate it with per-stage DATA_W.

Verification
REQ-030 Reset then inValid 1, inData 0xA5 for one cycle, outReady 1 -> outValid 1, outData 0xA5 on the next cycle, then outValid 0 and outData 0.
REQ-031 Stream 1,2,3,4 with outReady 0 for two cycles -> occupancy reaches 2, inReady drops, outData holds 1; after outReady returns, out order is 1,2,3,4 with none lost.
REQ-032 FULL holding 5,6, flush 1 with inValid 1 and inData 7 -> next cycle occupancy 0, outValid 0, outData 0, inReady 1; 7 never appears.
REQ-033 rstN pulsed low between edges while FULL -> outputs reach reset values before the next edge; a subsequent beat 0x3C emerges alone.
REQ-034 ZERO_BUBBLE 0, beat 0x11 then idle -> outData stays 0x11 while outValid is 0.
REQ-035 Random inValid and outReady for 10000 cycles against a scoreboard -> zero order or loss mismatches, and inReady is never 1 while occupancy is 2.

Source files
------------

// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline definitions: skid-stage occupancy states and the 32-bit NOP encoding.
package pipe_stage_skid_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  // RV32I addi x0,x0,0 used as the canonical pipeline NOP.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  function automatic logic [1:0] state_occupancy(input skid_state_e st);
    logic [1:0] occ;
    case (st)
      ST_EMPTY: occ = 2'd0;
      ST_HALF:  occ = 2'd1;
      ST_FULL:  occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// Pipeline register with a one-entry skid buffer; inReady is registered so that
// downstream stalls never reach upstream combinationally.
module pipe_stage_skid #(
  parameter int DATA_W      = 64,
  parameter bit ZERO_BUBBLE = 1'b1
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              inValid,
  input  logic [DATA_W-1:0] inData,
  output logic              inReady,
  output logic              outValid,
  output logic [DATA_W-1:0] outData,
  input  logic              outReady,
  input  logic              flush,
  output logic [1:0]        occupancy
);
  import pipe_stage_skid_pkg::*;

  skid_state_e       state_r;
  skid_state_e       state_nxt_s;
  logic [DATA_W-1:0] main_r;
  logic [DATA_W-1:0] main_nxt_s;
  logic [DATA_W-1:0] main_load_s;
  logic [DATA_W-1:0] skid_r;
  logic [DATA_W-1:0] skid_nxt_s;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [1:0]        occ_r;
  logic              in_xfer_s;
  logic              out_xfer_s;

  assign in_xfer_s  = inValid & in_ready_r;
  assign out_xfer_s = out_valid_r & outReady;

  // Next-state and payload routing; flush overrides any transfer.
  always_comb begin
    state_nxt_s = state_r;
    main_load_s = main_r;
    skid_nxt_s  = skid_r;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_xfer_s) begin
            state_nxt_s = ST_HALF;
            main_load_s = inData;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_HALF: begin
          if (in_xfer_s && out_xfer_s) begin
            state_nxt_s = ST_HALF;
            main_load_s = inData;
          end else if (out_xfer_s) begin
            state_nxt_s = ST_EMPTY;
          end else if (in_xfer_s) begin
            state_nxt_s = ST_FULL;
            skid_nxt_s  = inData;
          end else begin
            state_nxt_s = ST_HALF;
          end
        end
        ST_FULL: begin
          if (out_xfer_s) begin
            state_nxt_s = ST_HALF;
            main_load_s = skid_r;
          end else begin
            state_nxt_s = ST_FULL;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
        end
      endcase
    end
  end

  // Empty stage presents an all-zero bubble unless the last beat is to be held.
  always_comb begin
    main_nxt_s = main_load_s;
    if (ZERO_BUBBLE && (state_nxt_s == ST_EMPTY)) begin
      main_nxt_s = '0;
    end else begin
      main_nxt_s = main_load_s;
    end
  end

  // State, payload and registered handshake outputs.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_r     <= ST_EMPTY;
      main_r      <= '0;
      skid_r      <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      occ_r       <= 2'd0;
    end else begin
      state_r     <= state_nxt_s;
      main_r      <= main_nxt_s;
      skid_r      <= skid_nxt_s;
      in_ready_r  <= (state_nxt_s != ST_FULL);
      out_valid_r <= (state_nxt_s != ST_EMPTY);
      occ_r       <= state_occupancy(state_nxt_s);
    end
  end

  assign inReady   = in_ready_r;
  assign outValid  = out_valid_r;
  assign outData   = main_r;
  assign occupancy = occ_r;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomized checks of pipe_stage_skid against hand-computed values and a FIFO scoreboard.
module tb_pipe_stage_skid;

  logic       clk;
  logic       rstN;
  logic       inValid, inReady, outValid, outReady, flush;
  logic [7:0] inData, outData;
  logic [1:0] occupancy;
  logic       in_valid2, in_ready2, out_valid2, out_ready2, flush2;
  logic [7:0] in_data2, out_data2;
  logic [1:0] occ2;

  int n_cmp;
  int n_bad;

  pipe_stage_skid #(.DATA_W(8), .ZERO_BUBBLE(1'b1)) dut (
    .clk(clk), .rstN(rstN), .inValid(inValid), .inData(inData), .inReady(inReady),
    .outValid(outValid), .outData(outData), .outReady(outReady), .flush(flush),
    .occupancy(occupancy)
  );

  pipe_stage_skid #(.DATA_W(8), .ZERO_BUBBLE(1'b0)) dut_hold (
    .clk(clk), .rstN(rstN), .inValid(in_valid2), .inData(in_data2), .inReady(in_ready2),
    .outValid(out_valid2), .outData(out_data2), .outReady(out_ready2), .flush(flush2),
    .occupancy(occ2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstN = 1'b1; inValid = 1'b0; inData = 8'h00; outReady = 1'b0; flush = 1'b0;
    in_valid2 = 1'b0; in_data2 = 8'h00; out_ready2 = 1'b0; flush2 = 1'b0;
    #2 rstN = 1'b0;
    #1;
    n_cmp++; if (outValid !== 1'b0) begin n_bad++; $display("FAIL reset_outValid got %0h want 0", outValid); end
    n_cmp++; if (outData !== 8'h00) begin n_bad++; $display("FAIL reset_outData got %0h want 0", outData); end
    n_cmp++; if (inReady !== 1'b1) begin n_bad++; $display("FAIL reset_inReady got %0h want 1", inReady); end
    n_cmp++; if (occupancy !== 2'd0) begin n_bad++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
    repeat (2) @(posedge clk);
    #3 rstN = 1'b1;
  endtask

  task automatic test_single();
    inValid = 1'b1; inData = 8'hA5; outReady = 1'b1;
    tick();
    inValid = 1'b0; inData = 8'h00;
    n_cmp++; if (outValid !== 1'b1) begin n_bad++; $display("FAIL single_valid got %0h want 1", outValid); end
    n_cmp++; if (outData !== 8'hA5) begin n_bad++; $display("FAIL single_data got %0h want a5", outData); end
    n_cmp++; if (occupancy !== 2'd1) begin n_bad++; $display("FAIL single_occ got %0d want 1", occupancy); end
    tick();
    n_cmp++; if (outValid !== 1'b0) begin n_bad++; $display("FAIL single_drain_valid got %0h want 0", outValid); end
    n_cmp++; if (outData !== 8'h00) begin n_bad++; $display("FAIL single_bubble_data got %0h want 0", outData); end
    n_cmp++; if (inReady !== 1'b1) begin n_bad++; $display("FAIL single_inReady got %0h want 1", inReady); end
  endtask

  // Stream 1..4 with a two-cycle downstream stall; collect beats in consumption order.
  task automatic test_back_to_back();
    logic [7:0] got [0:7];
    int  sent;
    int  rcvd;
    bit  acc_in, acc_out;
    logic [7:0] cur;
    sent = 0; rcvd = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      outReady = (cyc >= 2);
      inValid  = (sent < 4);
      inData   = 8'(sent + 1);
      acc_in   = inValid && inReady;
      acc_out  = outValid && outReady;
      cur      = outData;
      tick();
      if (acc_in) sent++;
      if (acc_out && rcvd < 8) begin got[rcvd] = cur; rcvd++; end
      if (cyc == 1) begin
        n_cmp++; if (occupancy !== 2'd2) begin n_bad++; $display("FAIL stall_occ got %0d want 2", occupancy); end
        n_cmp++; if (inReady !== 1'b0) begin n_bad++; $display("FAIL stall_inReady got %0h want 0", inReady); end
        n_cmp++; if (outData !== 8'h01) begin n_bad++; $display("FAIL stall_hold got %0h want 1", outData); end
      end
    end
    inValid = 1'b0;
    n_cmp++; if (rcvd !== 4) begin n_bad++; $display("FAIL stream_count got %0d want 4", rcvd); end
    for (int i = 0; i < 4; i++) begin
      if (i < rcvd) begin
        n_cmp++; if (got[i] !== 8'(i + 1)) begin n_bad++; $display("FAIL stream_order[%0d] got %0h want %0h", i, got[i], i + 1); end
      end
    end
    n_cmp++; if (occupancy !== 2'd0) begin n_bad++; $display("FAIL stream_drained got %0d want 0", occupancy); end
  endtask

  task automatic fill_full(input logic [7:0] a, input logic [7:0] b);
    outReady = 1'b0; inValid = 1'b1; inData = a;
    tick();
    inData = b;
    tick();
    inValid = 1'b0; inData = 8'h00;
  endtask

  task automatic test_flush();
    fill_full(8'h05, 8'h06);
    n_cmp++; if (occupancy !== 2'd2) begin n_bad++; $display("FAIL flush_pre_occ got %0d want 2", occupancy); end
    flush = 1'b1; inValid = 1'b1; inData = 8'h07;
    tick();
    flush = 1'b0; inValid = 1'b0; inData = 8'h00;
    n_cmp++; if (occupancy !== 2'd0) begin n_bad++; $display("FAIL flush_occ got %0d want 0", occupancy); end
    n_cmp++; if (outValid !== 1'b0) begin n_bad++; $display("FAIL flush_valid got %0h want 0", outValid); end
    n_cmp++; if (outData !== 8'h00) begin n_bad++; $display("FAIL flush_data got %0h want 0", outData); end
    n_cmp++; if (inReady !== 1'b1) begin n_bad++; $display("FAIL flush_inReady got %0h want 1", inReady); end
    outReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (outValid !== 1'b0) begin n_bad++; $display("FAIL flush_no7 got valid %0h data %0h want valid 0", outValid, outData); end
    end
    // A beat consumed on the flush edge is not replayed.
    inValid = 1'b1; inData = 8'h08;
    tick();
    inValid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++; if (outValid !== 1'b0) begin n_bad++; $display("FAIL flush_noreplay got %0h want 0", outValid); end
  endtask

  task automatic test_async_reset();
    fill_full(8'h21, 8'h22);
    #2 rstN = 1'b0;
    #1;
    n_cmp++; if (outValid !== 1'b0) begin n_bad++; $display("FAIL areset_valid got %0h want 0", outValid); end
    n_cmp++; if (outData !== 8'h00) begin n_bad++; $display("FAIL areset_data got %0h want 0", outData); end
    n_cmp++; if (inReady !== 1'b1) begin n_bad++; $display("FAIL areset_inReady got %0h want 1", inReady); end
    n_cmp++; if (occupancy !== 2'd0) begin n_bad++; $display("FAIL areset_occ got %0d want 0", occupancy); end
    #1 rstN = 1'b1;
    inValid = 1'b1; inData = 8'h3C; outReady = 1'b1;
    tick();
    inValid = 1'b0; inData = 8'h00;
    n_cmp++; if (outData !== 8'h3C || outValid !== 1'b1) begin n_bad++; $display("FAIL areset_beat got %0h/%0h want 1/3c", outValid, outData); end
    n_cmp++; if (occupancy !== 2'd1) begin n_bad++; $display("FAIL areset_beat_occ got %0d want 1", occupancy); end
    tick();
    n_cmp++; if (outValid !== 1'b0) begin n_bad++; $display("FAIL areset_alone got %0h want 0", outValid); end
  endtask

  task automatic test_hold_bubble();
    in_valid2 = 1'b1; in_data2 = 8'h11; out_ready2 = 1'b1;
    tick();
    in_valid2 = 1'b0; in_data2 = 8'h00;
    n_cmp++; if (out_valid2 !== 1'b1 || out_data2 !== 8'h11) begin n_bad++; $display("FAIL hold_beat got %0h/%0h want 1/11", out_valid2, out_data2); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (out_valid2 !== 1'b0) begin n_bad++; $display("FAIL hold_valid got %0h want 0", out_valid2); end
      n_cmp++; if (out_data2 !== 8'h11) begin n_bad++; $display("FAIL hold_data got %0h want 11", out_data2); end
    end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    bit acc_in, acc_out;
    for (int cyc = 0; cyc < 10030; cyc++) begin
      n_cmp++; if (inReady === 1'b1 && occupancy === 2'd2) begin n_bad++; $display("FAIL rand_ready_full cyc %0d", cyc); end
      if (cyc < 10000) begin
        inValid  = 1'($urandom_range(0, 1));
        outReady = 1'($urandom_range(0, 1));
        inData   = 8'($urandom);
      end else begin
        inValid = 1'b0; outReady = 1'b1;
      end
      acc_in  = inValid && inReady;
      acc_out = outValid && outReady;
      if (acc_out) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++; $display("FAIL rand_extra_beat got %0h want none", outData);
        end else begin
          if (outData !== q[0]) begin n_bad++; $display("FAIL rand_order got %0h want %0h", outData, q[0]); end
          void'(q.pop_front());
        end
      end
      if (acc_in) q.push_back(inData);
      tick();
    end
    n_cmp++; if (q.size() != 0) begin n_bad++; $display("FAIL rand_lost got %0d left want 0", q.size()); end
    n_cmp++; if (outValid !== 1'b0) begin n_bad++; $display("FAIL rand_drain got %0h want 0", outValid); end
    inValid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_hold_bubble();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
